// File: rtl/capture_pkg.sv
// Shared definitions for the image-capture path: packer state encoding,
// pixels-per-word derivation and counter sizing used on both sides of the FIFO.
package capture_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    ARMED   = ST_ARMED,
    CAPTURE = ST_CAPTURE,
    DONE    = ST_DONE
  } packer_state_t;

  function automatic int pixels_per_word(input int data_width, input int pixel_width);
    return data_width / pixel_width;
  endfunction

  // A counter for a single-entry range still needs one bit to exist.
  function automatic int counter_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pixel_shift_packer.sv
// Little-endian pixel-to-word assembler: slot counter, slot insert with zero fill,
// and the word-complete flag for the pixel being accepted this cycle.
module pixel_shift_packer
  import capture_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   pixel_accept,
  input  logic                   line_end,
  input  logic [PIXEL_WIDTH-1:0] pixel_data,
  output logic                   word_complete,
  output logic [DATA_WIDTH-1:0]  word_data
);

  localparam int PPW    = pixels_per_word(DATA_WIDTH, PIXEL_WIDTH);
  localparam int SLOT_W = counter_width(PPW);

  logic [SLOT_W-1:0]     slot_reg, slot_next, slot_base;
  logic [DATA_WIDTH-1:0] data_reg, data_next, data_base;

  // Clearing and accepting in the same cycle makes the current pixel slot 0.
  assign slot_base = clear ? '0 : slot_reg;
  assign data_base = clear ? '0 : data_reg;

  genvar gi;
  generate
    for (gi = 0; gi < PPW; gi++) begin : g_slot
      assign word_data[gi*PIXEL_WIDTH +: PIXEL_WIDTH] =
        (pixel_accept && (slot_base == SLOT_W'(gi))) ? pixel_data
                                                     : data_base[gi*PIXEL_WIDTH +: PIXEL_WIDTH];
    end
  endgenerate

  assign word_complete = pixel_accept && ((slot_base == SLOT_W'(PPW - 1)) || line_end);

  // Emptied slots are kept at zero so short words come out zero-padded.
  always_comb begin
    slot_next = slot_base;
    data_next = data_base;
    if (word_complete) begin
      slot_next = '0;
      data_next = '0;
    end else if (pixel_accept) begin
      slot_next = slot_base + SLOT_W'(1);
      data_next = word_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      slot_reg <= '0;
      data_reg <= '0;
    end else begin
      slot_reg <= slot_next;
      data_reg <= data_next;
    end
  end

endmodule

// File: rtl/pixel_word_packer.sv
// Camera-to-FIFO packer: capture FSM, line/frame geometry counters, FIFO push
// generation and dropped-word accounting around pixel_shift_packer.
module pixel_word_packer
  import capture_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int LINE_PIXELS = 640,
  parameter int FRAME_LINES = 480
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   frame_start,
  input  logic                   pixel_valid,
  input  logic [PIXEL_WIDTH-1:0] pixel_data,
  input  logic                   fifo_ready,
  input  logic                   fifo_full,
  output logic                   push_strobe,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   line_done,
  output logic                   frame_done,
  output logic                   frame_aborted,
  output logic                   overflow,
  output logic [15:0]            dropped_count,
  output logic                   busy
);

  localparam int PIX_W  = counter_width(LINE_PIXELS);
  localparam int LINE_W = counter_width(FRAME_LINES);

  packer_state_t state_reg, state_next;
  logic [PIX_W-1:0]      pix_cnt_reg, pix_cnt_next, pix_base;
  logic [LINE_W-1:0]     line_cnt_reg, line_cnt_next, line_base;
  logic                  restart, accept, line_end, frame_end, drop;
  logic                  word_complete;
  logic [DATA_WIDTH-1:0] word_data;

  logic                  push_strobe_reg, push_strobe_next;
  logic [DATA_WIDTH-1:0] out_data_reg, out_data_next;
  logic                  line_done_reg, line_done_next;
  logic                  frame_done_reg, frame_done_next;
  logic                  frame_aborted_reg, frame_aborted_next;
  logic                  overflow_reg, overflow_next;
  logic [15:0]           dropped_reg, dropped_next, dropped_base;

  // A frame_start in ARMED or CAPTURE begins a fresh frame on this very cycle.
  assign restart   = enable && frame_start && (state_reg == ARMED || state_reg == CAPTURE);
  assign accept    = enable && pixel_valid && (state_reg == CAPTURE || restart);
  assign pix_base  = restart ? '0 : pix_cnt_reg;
  assign line_base = restart ? '0 : line_cnt_reg;
  assign line_end  = (pix_base == PIX_W'(LINE_PIXELS - 1));
  assign frame_end = line_end && (line_base == LINE_W'(FRAME_LINES - 1));
  assign drop      = word_complete && (!fifo_ready || fifo_full);

  pixel_shift_packer #(
    .PIXEL_WIDTH(PIXEL_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clock        (clock),
    .reset_n      (reset_n),
    .clear        (restart || !enable),
    .pixel_accept (accept),
    .line_end     (line_end),
    .pixel_data   (pixel_data),
    .word_complete(word_complete),
    .word_data    (word_data)
  );

  always_comb begin
    state_next = state_reg;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    state_next = ARMED;
        ARMED:   if (frame_start) state_next = (accept && frame_end) ? DONE : CAPTURE;
        CAPTURE: if (accept && frame_end) state_next = DONE;
        DONE:    state_next = ARMED;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    pix_cnt_next  = enable ? pix_base  : '0;
    line_cnt_next = enable ? line_base : '0;
    if (accept) begin
      if (line_end) begin
        pix_cnt_next  = '0;
        line_cnt_next = frame_end ? '0 : line_base + LINE_W'(1);
      end else begin
        pix_cnt_next  = pix_base + PIX_W'(1);
      end
    end

    push_strobe_next   = word_complete && !drop;
    out_data_next      = push_strobe_next ? word_data : out_data_reg;
    line_done_next     = accept && line_end;
    frame_done_next    = accept && frame_end;
    frame_aborted_next = enable && frame_start && (state_reg == CAPTURE);

    // Drop accounting restarts with the frame, then records this cycle's loss.
    dropped_base  = restart ? 16'd0 : dropped_reg;
    overflow_next = restart ? 1'b0 : overflow_reg;
    dropped_next  = dropped_base;
    if (drop) begin
      overflow_next = 1'b1;
      if (dropped_base != 16'hFFFF) dropped_next = dropped_base + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg         <= IDLE;
      pix_cnt_reg       <= '0;
      line_cnt_reg      <= '0;
      push_strobe_reg   <= 1'b0;
      out_data_reg      <= '0;
      line_done_reg     <= 1'b0;
      frame_done_reg    <= 1'b0;
      frame_aborted_reg <= 1'b0;
      overflow_reg      <= 1'b0;
      dropped_reg       <= '0;
    end else begin
      state_reg         <= state_next;
      pix_cnt_reg       <= pix_cnt_next;
      line_cnt_reg      <= line_cnt_next;
      push_strobe_reg   <= push_strobe_next;
      out_data_reg      <= out_data_next;
      line_done_reg     <= line_done_next;
      frame_done_reg    <= frame_done_next;
      frame_aborted_reg <= frame_aborted_next;
      overflow_reg      <= overflow_next;
      dropped_reg       <= dropped_next;
    end
  end

  assign push_strobe   = push_strobe_reg;
  assign out_data      = out_data_reg;
  assign line_done     = line_done_reg;
  assign frame_done    = frame_done_reg;
  assign frame_aborted = frame_aborted_reg;
  assign overflow      = overflow_reg;
  assign dropped_count = dropped_reg;
  assign busy          = (state_reg == CAPTURE);

endmodule

// File: doc/pixel_word_packer.md
Name: pixel_word_packer

Overview:
- Upstream feeder of the image-capture FIFO: accepts camera pixels one per cycle and packs PIXEL_WIDTH pixels into DATA_WIDTH words.
- Drives the FIFO push strobe and data, and tracks line and frame geometry.
- Reports FIFO overflow as dropped words.
- Sits between the sensor interface and the FIFO `in_data` / `push_clock` inputs.

Parameters:
- PIXEL_WIDTH, 8, bits per pixel.
- DATA_WIDTH, 32, FIFO word width; must be an integer multiple of PIXEL_WIDTH. PPW = DATA_WIDTH/PIXEL_WIDTH.
- LINE_PIXELS, 640, pixels per line (>=1).
- FRAME_LINES, 480, lines per frame (>=1).

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset_n  in  1  synchronous active-low reset.
- enable  in  1  capture enable; low forces IDLE.
- frame_start  in  1  one-cycle pulse marking the first pixel cycle of a frame.
- pixel_valid  in  1  pixel_data valid this cycle.
- pixel_data  in  PIXEL_WIDTH  pixel value.
- fifo_ready  in  1  FIFO not busy/clearing.
- fifo_full  in  1  FIFO has no free slot.
- push_strobe  out  1  one-cycle push pulse to the FIFO.
- out_data  out  DATA_WIDTH  packed word; held until the next push.
- line_done  out  1  one-cycle pulse with the last word of each line.
- frame_done  out  1  one-cycle pulse with the last word of a frame.
- frame_aborted  out  1  one-cycle pulse when a frame is restarted mid-capture.
- overflow  out  1  sticky: at least one word dropped this frame.
- dropped_count  out  16  saturating count of dropped words this frame.
- busy  out  1  high in CAPTURE.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. reset_n low at a rising clock edge clears all state.
- Reset values: every output 0; state IDLE; packer slot, pixel and line counters 0.
- Reset mid-operation: any partial word is discarded and no strobe is issued.
- State machine: IDLE -> ARMED when enable=1. ARMED -> CAPTURE on frame_start. CAPTURE -> DONE after the last pixel of line FRAME_LINES-1. DONE -> ARMED next cycle. Any state -> IDLE next cycle when enable=0; partial word discarded, no strobe.
- frame_start with pixel_valid in the same cycle: that pixel is pixel 0 of line 0.
- Pixels with pixel_valid=1 in ARMED before frame_start are ignored.
- Packing: little-endian. Pixel k of a word goes to bits [k*PIXEL_WIDTH +: PIXEL_WIDTH]. The slot counter runs 0..PPW-1.
- A word completes when the slot reaches PPW-1, or on the last pixel of a line (pixel counter = LINE_PIXELS-1). A short word is zero-padded in the unused upper slots, and the slot counter resets to 0 at each line end.
- Latency: push_strobe and out_data update on the edge after the completing pixel. out_data is stable for the whole strobe cycle and holds until the next accepted word.
- line_done and frame_done are asserted in the same cycle as the strobe of the corresponding last word.
- Pixel counter width is clog2(LINE_PIXELS). It wraps to 0 at line end and increments the line counter. The line counter wraps to 0 at frame end.
- Drop rule: if a word completes while fifo_ready=0 or fifo_full=1 (sampled in the completing cycle), then:
  - no strobe is issued and out_data is unchanged;
  - overflow is set;
  - dropped_count increments, saturating at 16'hFFFF;
  - line_done and frame_done still pulse; counters still advance.
- overflow and dropped_count clear on the frame_start that begins a capture.
- frame_start during CAPTURE: frame_aborted pulses next cycle, the partial word is discarded, all counters restart, and the current pixel (if valid) becomes pixel 0. overflow and dropped_count clear.
- pixel_valid gaps (0) stall packing without penalty. No back-pressure exists toward the sensor.

Decomposition:
- Shared package (capture_pkg):
  - packer state encoding localparams (IDLE, ARMED, CAPTURE, DONE);
  - PPW derivation;
  - a function for counter-width calculation, shared with the FIFO side.
- One natural sub-module: pixel_shift_packer. It holds the slot counter, the zero-fill/insert datapath and the word-complete flag. The top level holds the FSM, the geometry counters and the drop logic.

Test Plan:
- PIXEL_WIDTH=8, DATA_WIDTH=32, LINE_PIXELS=4, FRAME_LINES=1. Sequence: enable, frame_start with pixels 0x11, 0x22, 0x33, 0x44. Expect push_strobe one cycle after 0x44 with out_data=0x44332211, and line_done=frame_done=1 in that cycle.
- LINE_PIXELS=6, FRAME_LINES=2, pixels 0x11..0x66 per line. Expect words 0x44332211 and 0x00006655 per line, 4 strobes total, and frame_done only on the 4th strobe.
- fifo_full=1 during the second word of a line. Expect no strobe for that word, out_data still 0x44332211, overflow=1, dropped_count=1. Then the next frame_start clears both to 0.
- frame_start pulsed after 2 pixels of a 4-pixel line. Expect a frame_aborted pulse and no strobe for the partial word. The next 4 pixels 0xA1..0xA4 give 0xA4A3A2A1.
- reset_n=0 for one cycle after 3 pixels. Expect all outputs 0 and state IDLE. With enable held high, the FSM re-arms, and no strobe appears until a new frame_start plus 4 pixels.
- enable dropped mid-line, then raised again. Expect IDLE with no strobe for the partial word. The FSM returns to ARMED and ignores pixels until frame_start.
